// File: rtl/alu_pkg.sv
// Shared types and constants for the two-requester ALU arbiter.
// Opcode encoding, the undefined-op result, FSM states and the response bundle.
package alu_pkg;

    localparam int ALU_W   = 8;
    localparam int ALU_OPW = 3;

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_ROT = 3'b010,
        OP_XOR = 3'b011,
        OP_AND = 3'b100,
        OP_OR  = 3'b101
    } alu_op_e;

    localparam logic [ALU_W-1:0] UNDEF_RESULT = 8'hFF;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } arb_state_e;

    // Contents of the registered response channel.
    typedef struct packed {
        logic             id;
        logic [ALU_W-1:0] data;
        logic             carry;
        logic             zero;
        logic             err;
    } rsp_t;

endpackage

// File: rtl/alu_core.sv
// Purely combinational 8-bit ALU: add, sub, rotate-left, xor, and, or.
// Ports: a, b, op in; result, carry (add/sub only), err (undefined op) out.
module alu_core
    import alu_pkg::*;
#(
    parameter int W   = ALU_W,
    parameter int OPW = ALU_OPW
) (
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    input  logic [OPW-1:0] op,
    output logic [W-1:0]   result,
    output logic           carry,
    output logic           err
);

    logic [W:0]   add_w;
    logic [W:0]   sub_w;
    logic [W-1:0] rot4;
    logic [W-1:0] rot2;
    logic [W-1:0] rot1;

    assign add_w = {1'b0, a} + {1'b0, b};

    // Two's complement subtract; bit W is the
    // no-borrow flag, i.e. set when a >= b.
    assign sub_w = {1'b0, a} + {1'b0, ~b}
                 + {{W{1'b0}}, 1'b1};

    // Rotate left as a 4/2/1 barrel.
    assign rot4 = b[2] ? {a[W-5:0], a[W-1:W-4]}
                       : a;
    assign rot2 = b[1] ? {rot4[W-3:0], rot4[W-1:W-2]}
                       : rot4;
    assign rot1 = b[0] ? {rot2[W-2:0], rot2[W-1]}
                       : rot2;

    always_comb begin
        result = '0;
        carry  = 1'b0;
        err    = 1'b0;
        case (op)
            OP_ADD: begin
                result = add_w[W-1:0];
                carry  = add_w[W];
            end
            OP_SUB: begin
                result = sub_w[W-1:0];
                carry  = sub_w[W];
            end
            OP_ROT: result = rot1;
            OP_XOR: result = a ^ b;
            OP_AND: result = a & b;
            OP_OR:  result = a | b;
            default: begin
                result = UNDEF_RESULT;
                err    = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one ALU between two requesters, with a
// one-entry registered response channel tagged by requester id.
// Ports: clk, rst_n; req_valid/req_ready[1:0], req_a*/req_b*/req_op*;
// rsp_valid/rsp_ready, rsp_id, rsp_data, rsp_carry, rsp_zero, rsp_err.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int W   = ALU_W,
    parameter int OPW = ALU_OPW
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [1:0]     req_valid,
    output logic [1:0]     req_ready,
    input  logic [W-1:0]   req_a0,
    input  logic [W-1:0]   req_a1,
    input  logic [W-1:0]   req_b0,
    input  logic [W-1:0]   req_b1,
    input  logic [OPW-1:0] req_op0,
    input  logic [OPW-1:0] req_op1,
    output logic           rsp_valid,
    input  logic           rsp_ready,
    output logic           rsp_id,
    output logic [W-1:0]   rsp_data,
    output logic           rsp_carry,
    output logic           rsp_zero,
    output logic           rsp_err
);

    arb_state_e state_q;
    arb_state_e state_d;
    logic       last_q;
    logic       last_d;
    rsp_t       rsp_q;
    rsp_t       rsp_d;

    logic           gnt_id;
    logic           any_valid;
    logic           can_accept;
    logic           xfer;
    logic [W-1:0]   alu_a;
    logic [W-1:0]   alu_b;
    logic [OPW-1:0] alu_op;
    logic [W-1:0]   alu_res;
    logic           alu_carry;
    logic           alu_err;

    // Grant selection: contention goes to the
    // requester that did not win last time.
    always_comb begin
        gnt_id = 1'b0;
        case (req_valid)
            2'b11:   gnt_id = ~last_q;
            2'b10:   gnt_id = 1'b1;
            default: gnt_id = 1'b0;
        endcase
    end

    assign any_valid = |req_valid;

    assign alu_a  = gnt_id ? req_a1  : req_a0;
    assign alu_b  = gnt_id ? req_b1  : req_b0;
    assign alu_op = gnt_id ? req_op1 : req_op0;

    alu_core #(
        .W   (W),
        .OPW (OPW)
    ) u_core (
        .a      (alu_a),
        .b      (alu_b),
        .op     (alu_op),
        .result (alu_res),
        .carry  (alu_carry),
        .err    (alu_err)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
            last_q  <= 1'b1;
            rsp_q   <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            rsp_q   <= rsp_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            EMPTY: begin
                if (xfer) state_d = FULL;
            end
            FULL: begin
                if (rsp_ready && !xfer)
                    state_d = EMPTY;
            end
            default: state_d = EMPTY;
        endcase
    end

    // Response register and round-robin pointer
    // only move on an accepted transfer.
    always_comb begin
        rsp_d  = rsp_q;
        last_d = last_q;
        if (xfer) begin
            rsp_d.id    = gnt_id;
            rsp_d.data  = alu_res;
            rsp_d.carry = alu_carry;
            rsp_d.zero  = (alu_res == '0);
            rsp_d.err   = alu_err;
            last_d      = gnt_id;
        end
    end

    // Outputs. req_ready is forced low in reset so
    // nothing looks accepted while flops are held.
    always_comb begin
        rsp_valid  = (state_q == FULL);
        can_accept = !rsp_valid || rsp_ready;
        xfer       = any_valid && can_accept;
        req_ready  = 2'b00;
        if (rst_n && xfer)
            req_ready[gnt_id] = 1'b1;
    end

    assign rsp_id    = rsp_q.id;
    assign rsp_data  = rsp_q.data;
    assign rsp_carry = rsp_q.carry;
    assign rsp_zero  = rsp_q.zero;
    assign rsp_err   = rsp_q.err;

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed vectors plus randomized
// traffic checked against an arithmetic reference and arbitration model.
module tb_alu_arbiter;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] req_valid = 2'b00;
    logic [1:0] req_ready;
    logic [7:0] req_a0 = '0, req_a1 = '0;
    logic [7:0] req_b0 = '0, req_b1 = '0;
    logic [2:0] req_op0 = '0, req_op1 = '0;
    logic       rsp_valid;
    logic       rsp_ready = 1'b1;
    logic       rsp_id;
    logic [7:0] rsp_data;
    logic       rsp_carry;
    logic       rsp_zero;
    logic       rsp_err;

    int checks = 0;
    int failures = 0;

    alu_arbiter dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a0    (req_a0),
        .req_a1    (req_a1),
        .req_b0    (req_b0),
        .req_b1    (req_b1),
        .req_op0   (req_op0),
        .req_op1   (req_op1),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_data  (rsp_data),
        .rsp_carry (rsp_carry),
        .rsp_zero  (rsp_zero),
        .rsp_err   (rsp_err)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // Reference ALU from plain integer arithmetic.
    function automatic void alu_ref(
        input  logic [7:0] a,
        input  logic [7:0] b,
        input  logic [2:0] op,
        output logic [7:0] d,
        output logic       c,
        output logic       e
    );
        int ia, ib, sh, r;
        ia = int'(a);
        ib = int'(b);
        c = 1'b0;
        e = 1'b0;
        r = 0;
        case (op)
            3'd0: begin r = ia + ib; c = (r > 255); end
            3'd1: begin r = ia - ib + 256; c = (ia >= ib); end
            3'd2: begin
                sh = ib % 8;
                r = (ia << sh) | (ia >> (8 - sh));
            end
            3'd3: r = ia ^ ib;
            3'd4: r = ia & ib;
            3'd5: r = ia | ib;
            default: begin r = 255; e = 1'b1; end
        endcase
        d = 8'(r % 256);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        req_valid = 2'b00;
        rsp_ready = 1'b1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        drive_idle();
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    // Present one request from a single requester for one cycle.
    task automatic send_one(input logic id, input logic [7:0] a,
                            input logic [7:0] b, input logic [2:0] op);
        rsp_ready = 1'b1;
        if (id) begin
            req_a1 = a; req_b1 = b; req_op1 = op;
            req_a0 = 8'($urandom); req_b0 = 8'($urandom);
            req_op0 = 3'($urandom);
            req_valid = 2'b10;
        end else begin
            req_a0 = a; req_b0 = b; req_op0 = op;
            req_a1 = 8'($urandom); req_b1 = 8'($urandom);
            req_op1 = 3'($urandom);
            req_valid = 2'b01;
        end
        tick();
        req_valid = 2'b00;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req_valid = 2'b11;
        rsp_ready = 1'b1;
        req_a0 = 8'h19; req_b0 = 8'h1E; req_op0 = 3'd0;
        tick();
        tick();
        checks++;
        if (req_ready !== 2'b00) begin
            failures++;
            $display("FAIL reset_ready: got %b want 00", req_ready);
        end
        checks++;
        if ({rsp_valid, rsp_id, rsp_data, rsp_carry, rsp_zero, rsp_err}
                !== 13'd0) begin
            failures++;
            $display("FAIL reset_rsp: got v=%b id=%b d=%h c=%b z=%b e=%b want all 0",
                     rsp_valid, rsp_id, rsp_data, rsp_carry, rsp_zero, rsp_err);
        end
        rst_n = 1'b1;
        req_valid = 2'b00;
        tick();
        checks++;
        if (rsp_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_no_accept: rsp_valid got %b want 0", rsp_valid);
        end
    endtask

    task automatic test_directed();
        logic       vid [8];
        logic [7:0] va  [8];
        logic [7:0] vb  [8];
        logic [2:0] vop [8];
        logic [7:0] vd  [8];
        logic       vc  [8];
        logic       vz  [8];
        vid = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        va  = '{8'h19, 8'h1E, 8'h19, 8'h0A, 8'h0F, 8'h1F, 8'h0C, 8'h80};
        vb  = '{8'h1E, 8'h19, 8'h1E, 8'h05, 8'h03, 8'h03, 8'h05, 8'h80};
        vop = '{3'd0, 3'd1, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd0};
        vd  = '{8'h37, 8'h05, 8'hFB, 8'h41, 8'h0C, 8'h03, 8'h0D, 8'h00};
        vc  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        vz  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        do_reset();
        for (int i = 0; i < 8; i++) begin
            send_one(vid[i], va[i], vb[i], vop[i]);
            checks++;
            if ({rsp_valid, rsp_id, rsp_data, rsp_carry, rsp_zero, rsp_err}
                    !== {1'b1, vid[i], vd[i], vc[i], vz[i], 1'b0}) begin
                failures++;
                $display("FAIL directed_%0d: got v=%b id=%b d=%h c=%b z=%b e=%b want v=1 id=%b d=%h c=%b z=%b e=0",
                         i, rsp_valid, rsp_id, rsp_data, rsp_carry, rsp_zero,
                         rsp_err, vid[i], vd[i], vc[i], vz[i]);
            end
        end
        tick();
    endtask

    task automatic test_undef();
        logic       id;
        logic [2:0] op;
        for (int i = 0; i < 4; i++) begin
            id = 1'($urandom);
            op = (i % 2 == 0) ? 3'd6 : 3'd7;
            send_one(id, 8'($urandom), 8'($urandom), op);
            checks++;
            if ({rsp_valid, rsp_id, rsp_data, rsp_carry, rsp_zero, rsp_err}
                    !== {1'b1, id, 8'hFF, 1'b0, 1'b0, 1'b1}) begin
                failures++;
                $display("FAIL undef_op%0d: got v=%b id=%b d=%h c=%b z=%b e=%b want v=1 id=%b d=ff c=0 z=0 e=1",
                         op, rsp_valid, rsp_id, rsp_data, rsp_carry,
                         rsp_zero, rsp_err, id);
            end
        end
        tick();
    endtask

    task automatic test_back_to_back();
        logic [1:0] exp_rdy;
        logic [7:0] exp_d;
        do_reset();
        req_valid = 2'b11;
        rsp_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            req_a0 = 8'(i); req_b0 = 8'h01; req_op0 = 3'd0;
            req_a1 = 8'h55; req_b1 = 8'(i); req_op1 = 3'd3;
            #1;
            exp_rdy = (i % 2 == 0) ? 2'b01 : 2'b10;
            exp_d = (i % 2 == 0) ? 8'(i + 1) : (8'h55 ^ 8'(i));
            checks++;
            if (req_ready !== exp_rdy) begin
                failures++;
                $display("FAIL rr_ready_%0d: got %b want %b", i, req_ready, exp_rdy);
            end
            tick();
            checks++;
            if ({rsp_valid, rsp_id, rsp_data} !==
                    {1'b1, exp_rdy[1], exp_d}) begin
                failures++;
                $display("FAIL rr_rsp_%0d: got v=%b id=%b d=%h want v=1 id=%b d=%h",
                         i, rsp_valid, rsp_id, rsp_data, exp_rdy[1], exp_d);
            end
        end
        drive_idle();
        tick();
    endtask

    task automatic test_backpressure();
        do_reset();
        send_one(1'b0, 8'h12, 8'h34, 3'd0);
        rsp_ready = 1'b0;
        req_valid = 2'b11;
        req_a0 = 8'hAA; req_b0 = 8'h01; req_op0 = 3'd0;
        req_a1 = 8'hF3; req_b1 = 8'h3C; req_op1 = 3'd4;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (req_ready !== 2'b00) begin
                failures++;
                $display("FAIL bp_ready_%0d: got %b want 00", i, req_ready);
            end
            tick();
            checks++;
            if ({rsp_valid, rsp_id, rsp_data, rsp_carry, rsp_zero, rsp_err}
                    !== {1'b1, 1'b0, 8'h46, 3'b000}) begin
                failures++;
                $display("FAIL bp_hold_%0d: got v=%b id=%b d=%h c=%b z=%b e=%b want v=1 id=0 d=46 c=0 z=0 e=0",
                         i, rsp_valid, rsp_id, rsp_data, rsp_carry,
                         rsp_zero, rsp_err);
            end
        end
        rsp_ready = 1'b1;
        #1;
        checks++;
        if (req_ready !== 2'b10) begin
            failures++;
            $display("FAIL bp_release_ready: got %b want 10", req_ready);
        end
        tick();
        checks++;
        if ({rsp_valid, rsp_id, rsp_data} !== {1'b1, 1'b1, 8'h30}) begin
            failures++;
            $display("FAIL bp_pop_accept: got v=%b id=%b d=%h want v=1 id=1 d=30",
                     rsp_valid, rsp_id, rsp_data);
        end
        rsp_ready = 1'b0;
        tick();
        rst_n = 1'b0;
        #1;
        checks++;
        if ({rsp_valid, req_ready} !== 3'b000) begin
            failures++;
            $display("FAIL reset_mid: got v=%b ready=%b want v=0 ready=00",
                     rsp_valid, req_ready);
        end
        tick();
        rst_n = 1'b1;
        drive_idle();
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (rsp_valid !== 1'b0) begin
                failures++;
                $display("FAIL reset_discard_%0d: rsp_valid got %b want 0",
                         i, rsp_valid);
            end
        end
    endtask

    task automatic test_random();
        logic       m_last;
        logic       m_full;
        logic       m_id;
        logic [7:0] m_data;
        logic       m_carry;
        logic       m_zero;
        logic       m_err;
        logic       can;
        logic       g;
        logic [1:0] exp_rdy;
        do_reset();
        m_last = 1'b1;
        m_full = 1'b0;
        m_id = 1'b0; m_data = '0;
        m_carry = 1'b0; m_zero = 1'b0; m_err = 1'b0;
        for (int i = 0; i < 400; i++) begin
            checks++;
            if (rsp_valid !== m_full) begin
                failures++;
                $display("FAIL rand_valid_%0d: got %b want %b", i, rsp_valid, m_full);
            end else if (m_full) begin
                checks++;
                if ({rsp_id, rsp_data, rsp_carry, rsp_zero, rsp_err} !==
                        {m_id, m_data, m_carry, m_zero, m_err}) begin
                    failures++;
                    $display("FAIL rand_rsp_%0d: got id=%b d=%h c=%b z=%b e=%b want id=%b d=%h c=%b z=%b e=%b",
                             i, rsp_id, rsp_data, rsp_carry, rsp_zero, rsp_err,
                             m_id, m_data, m_carry, m_zero, m_err);
                end
            end
            req_valid = 2'($urandom);
            rsp_ready = ($urandom_range(0, 3) != 0);
            req_a0 = 8'($urandom); req_b0 = 8'($urandom);
            req_op0 = 3'($urandom);
            req_a1 = 8'($urandom); req_b1 = 8'($urandom);
            req_op1 = 3'($urandom);
            #1;
            can = !m_full || rsp_ready;
            g = (req_valid == 2'b11) ? ~m_last : req_valid[1];
            exp_rdy = 2'b00;
            if (req_valid != 2'b00 && can)
                exp_rdy = g ? 2'b10 : 2'b01;
            checks++;
            if (req_ready !== exp_rdy) begin
                failures++;
                $display("FAIL rand_ready_%0d: got %b want %b", i, req_ready, exp_rdy);
            end
            if (exp_rdy != 2'b00) begin
                if (g)
                    alu_ref(req_a1, req_b1, req_op1, m_data, m_carry, m_err);
                else
                    alu_ref(req_a0, req_b0, req_op0, m_data, m_carry, m_err);
                m_zero = (m_data == 8'h00);
                m_id = g;
                m_last = g;
                m_full = 1'b1;
            end else if (rsp_ready) begin
                m_full = 1'b0;
            end
            tick();
        end
        drive_idle();
        tick();
    endtask

    initial begin
        test_reset();
        test_directed();
        test_undef();
        test_back_to_back();
        test_backpressure();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Round-robin arbiter and result sequencer that shares one 8-bit ALU datapath between two requesters. The datapath covers add, sub, rotate, xor, and, or, plus undefined opcodes. Each requester issues an operation through a valid/ready handshake. The arbiter grants one request per cycle, computes the result, and returns it through a registered response channel tagged with the requester id. It sits between the instruction-issue logic and the ALU.

## Interface
Parameters:
- W, 8, operand/result width (fixed at 8 for this revision)
- OPW, 3, opcode width

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  2  per-requester request valid
- req_ready  out  2  per-requester accept; a transfer occurs when valid & ready
- req_a0, req_a1  in  8  operand a, requester 0/1
- req_b0, req_b1  in  8  operand b, requester 0/1
- req_op0, req_op1  in  3  opcode, requester 0/1
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response consumer ready
- rsp_id  out  1  requester that issued this result
- rsp_data  out  8  ALU result
- rsp_carry  out  1  carry-out for add/sub; 0 otherwise
- rsp_zero  out  1  rsp_data == 0
- rsp_err  out  1  opcode was undefined (110/111)

## Operation
- Opcodes:
  - 000 add: a+b, carry-in 0.
  - 001 sub: a+~b+1; rsp_carry=1 when a>=b (unsigned).
  - 010 rotate a left by b[2:0]. Implemented as three stages (4, 2, 1) selected by b[2], b[1], b[0].
  - 011 xor.
  - 100 and.
  - 101 or.
  - 110/111: rsp_data=0xFF, rsp_err=1.
- Results are modulo 2^8; carry is reported only via rsp_carry.
- Round-robin pointer `last` (1 bit) holds the id of the last granted requester.
  - When both requesters are valid, grant goes to ~last.
  - When only one is valid, grant goes to it.
  - `last` updates only on an accepted transfer.
- Accept condition: `can_accept = !rsp_valid || rsp_ready`.
  - req_ready[g] = can_accept for the granted requester g; req_ready of the other requester is 0.
  - When neither requester is valid, req_ready = 00.
- req_ready depends combinationally on req_valid, rsp_valid, rsp_ready and `last`. It does not depend on operand or opcode values.
- FSM states:
  - EMPTY: no response held.
    - Transfer → FULL.
  - FULL: response held.
    - rsp_ready & transfer → FULL (the response register is overwritten in the same cycle).
    - rsp_ready & no transfer → EMPTY.
    - !rsp_ready → FULL, response held stable.
- While FULL and !rsp_ready, all rsp_* outputs are held stable and no transfer is accepted.
- Reset mid-operation discards any held response; requests presented during reset are not accepted.

## Timing
- Reset values:
  - rsp_valid=0, rsp_id=0, rsp_data=0x00, rsp_carry=0, rsp_zero=0, rsp_err=0.
  - last=1, so requester 0 wins the first contention.
  - State EMPTY.
- req_ready=00 while rst_n=0.
- Latency: a transfer in cycle N gives rsp_valid=1 with the result in cycle N+1.
- Throughput: one operation per cycle when rsp_ready is held high.
- Simultaneous response pop and new accept in the same cycle is legal and loses no bubble.
- A requester that holds req_valid high is granted within 2 accepted transfers (no starvation).
- rsp_* are registered outputs. Only req_ready is combinational.

## Structure
- Shared package alu_pkg:
  - Opcode enum: OP_ADD=000, OP_SUB=001, OP_ROT=010, OP_XOR=011, OP_AND=100, OP_OR=101.
  - Constant UNDEF_RESULT=8'hFF.
  - FSM state enum {EMPTY, FULL}.
- Sub-module alu_core: purely combinational.
  - Inputs: a, b, op.
  - Outputs: result, carry, err.
  - Instantiated once on the granted operands.
- Arbitration, the FSM and the response register live in alu_arbiter.

## Test plan
- Reset, then requester 0 sends a=0x19, b=0x1E, op=000 → next cycle rsp_valid=1, rsp_id=0, rsp_data=0x37, rsp_carry=0, rsp_err=0.
- Requester 1 sends a=0x1E, b=0x19, op=001 → rsp_data=0x05, rsp_carry=1, rsp_id=1. Then a=0x19, b=0x1E, op=001 → rsp_data=0xFB, rsp_carry=0.
- Rotate and logic ops:
  - a=0x0A, b=0x05, op=010 → 0x41.
  - a=0x0F, b=0x03, op=011 → 0x0C.
  - a=0x1F, b=0x03, op=100 → 0x03.
  - a=0x0C, b=0x05, op=101 → 0x0D.
  - a=0x80, b=0x80, op=000 → 0x00, carry=1, zero=1.
- op=110 and op=111 with any operands → rsp_data=0xFF, rsp_err=1.
- Both requesters continuously valid with rsp_ready=1 for 6 cycles after reset → granted ids alternate 0,1,0,1,0,1 with one response per cycle.
- Backpressure:
  - With rsp_ready=0 for 3 cycles while FULL → req_ready=00 and rsp_* stable.
  - On rsp_ready=1 → pop and a new accept occur in the same cycle.
  - Assert rst_n=0 while FULL → rsp_valid=0 immediately, and the held result is never delivered.
